// File: rtl/cnfg_reg_access_if.sv
// Register-access bus between decoder, sequencer, register file and readback.
// slave = sequencer side; master = decoder / register file / readback side.
interface cnfg_reg_access_if #(
    parameter int CMD_ADDR_W = 6,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 16
);
    logic                  Start;
    logic                  OpRead;
    logic                  SerIn;
    logic                  SerValid;
    logic                  Abort;
    logic                  Busy;
    logic [REG_ADDR_W-1:0] Addr;
    logic [DATA_W-1:0]     DataIn;
    logic                  WE;
    logic [DATA_W-1:0]     DataOut;
    logic                  RbValid;
    logic                  RbReady;
    logic [CMD_ADDR_W-1:0] RbAddr;
    logic [DATA_W-1:0]     RbData;
    logic                  AddrErr;

    modport slave (
        input  Start, OpRead, SerIn, SerValid, Abort, DataOut, RbReady,
        output Busy, Addr, DataIn, WE, RbValid, RbAddr, RbData, AddrErr
    );

    modport master (
        output Start, OpRead, SerIn, SerValid, Abort, DataOut, RbReady,
        input  Busy, Addr, DataIn, WE, RbValid, RbAddr, RbData, AddrErr
    );
endinterface

// File: rtl/cnfg_reg_access.sv
// Register-access sequencer: deserialises WrRegister/RdRegister payloads,
// sequences latch-safe writes and hands read words to the readback path.
module cnfg_reg_access #(
    parameter int CMD_ADDR_W = 6,
    parameter int REG_ADDR_W = 5,
    parameter int DATA_W     = 16,
    parameter int WE_CYCLES  = 1
) (
    input  logic             Clk,
    input  logic             ResetB,
    cnfg_reg_access_if.slave bus
);
    localparam int CNT_W = $clog2((DATA_W > CMD_ADDR_W) ? DATA_W : CMD_ADDR_W);

    localparam logic [3:0] IDLE     = 4'd0;
    localparam logic [3:0] S_ADDR   = 4'd1;
    localparam logic [3:0] S_DATA   = 4'd2;
    localparam logic [3:0] WR_SET   = 4'd3;
    localparam logic [3:0] WR_PULSE = 4'd4;
    localparam logic [3:0] WR_HOLD  = 4'd5;
    localparam logic [3:0] RD_SET   = 4'd6;
    localparam logic [3:0] RD_CAP   = 4'd7;
    localparam logic [3:0] RD_OUT   = 4'd8;
    localparam logic [3:0] ADDR_ERR = 4'd9;

    localparam logic [CNT_W-1:0] ADDR_LAST  = CNT_W'(CMD_ADDR_W - 1);
    localparam logic [CNT_W-1:0] DATA_LAST  = CNT_W'(DATA_W - 1);
    localparam logic [1:0]       PULSE_LAST = 2'(WE_CYCLES - 1);

    logic [1:0]            rst_sync;
    logic                  rst_n;

    logic [3:0]            state;
    logic [3:0]            state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [1:0]            pcnt;
    logic [1:0]            pcnt_nxt;
    logic                  op_rd;
    logic                  op_nxt;
    logic [CMD_ADDR_W-1:0] addr_sr;
    logic [CMD_ADDR_W-1:0] addr_nxt;
    logic [CMD_ADDR_W-1:0] addr_sh;
    logic [DATA_W-1:0]     data_sr;
    logic [DATA_W-1:0]     data_nxt;
    logic [DATA_W-1:0]     data_sh;
    logic                  bad_sh;
    logic                  bad_sr;

    assign addr_sh = {addr_sr[CMD_ADDR_W-2:0], bus.SerIn};
    assign data_sh = {data_sr[DATA_W-2:0], bus.SerIn};
    assign bad_sh  = |addr_sh[CMD_ADDR_W-1:REG_ADDR_W];
    assign bad_sr  = |addr_sr[CMD_ADDR_W-1:REG_ADDR_W];

    // Reset assertion is immediate; release is aligned to the clock.
    always_ff @(posedge Clk or negedge ResetB) begin
        if (!ResetB) rst_sync <= 2'b00;
        else         rst_sync <= {rst_sync[0], 1'b1};
    end

    assign rst_n = rst_sync[1];

    // Next-state, shift and counter logic; Abort overrides everything.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        pcnt_nxt  = pcnt;
        op_nxt    = op_rd;
        addr_nxt  = addr_sr;
        data_nxt  = data_sr;
        case (state)
            IDLE: begin
                if (bus.Start) begin
                    state_nxt = S_ADDR;
                    cnt_nxt   = '0;
                    op_nxt    = bus.OpRead;
                end
            end
            S_ADDR: begin
                if (bus.SerValid) begin
                    addr_nxt = addr_sh;
                    if (cnt == ADDR_LAST) begin
                        cnt_nxt = '0;
                        if (!op_rd)      state_nxt = S_DATA;
                        else if (bad_sh) state_nxt = ADDR_ERR;
                        else             state_nxt = RD_SET;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            S_DATA: begin
                if (bus.SerValid) begin
                    data_nxt = data_sh;
                    if (cnt == DATA_LAST) begin
                        cnt_nxt   = '0;
                        state_nxt = bad_sr ? ADDR_ERR : WR_SET;
                    end else begin
                        cnt_nxt = cnt + 1'b1;
                    end
                end
            end
            WR_SET: begin
                state_nxt = WR_PULSE;
                pcnt_nxt  = '0;
            end
            WR_PULSE: begin
                if (pcnt == PULSE_LAST) state_nxt = WR_HOLD;
                else                    pcnt_nxt  = pcnt + 1'b1;
            end
            WR_HOLD:  state_nxt = IDLE;
            RD_SET:   state_nxt = RD_CAP;
            RD_CAP:   state_nxt = RD_OUT;
            RD_OUT: begin
                if (bus.RbReady) state_nxt = IDLE;
            end
            ADDR_ERR: state_nxt = IDLE;
            default:  state_nxt = IDLE;
        endcase
        if (bus.Abort) begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
            pcnt_nxt  = '0;
        end
    end

    // Sequencer state, counters and payload shift registers.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            pcnt    <= '0;
            op_rd   <= 1'b0;
            addr_sr <= '0;
            data_sr <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            pcnt    <= pcnt_nxt;
            op_rd   <= op_nxt;
            addr_sr <= addr_nxt;
            data_sr <= data_nxt;
        end
    end

    // Registered outputs; Addr/DataIn move only when entering a SET state.
    always_ff @(posedge Clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.Busy    <= 1'b0;
            bus.WE      <= 1'b0;
            bus.Addr    <= '0;
            bus.DataIn  <= '0;
            bus.RbValid <= 1'b0;
            bus.RbAddr  <= '0;
            bus.RbData  <= '0;
            bus.AddrErr <= 1'b0;
        end else begin
            bus.Busy    <= (state_nxt != IDLE);
            bus.WE      <= (state_nxt == WR_PULSE);
            bus.AddrErr <= (state_nxt == ADDR_ERR);
            bus.RbValid <= (state_nxt == RD_OUT);
            if (state_nxt == WR_SET) begin
                bus.Addr   <= addr_sr[REG_ADDR_W-1:0];
                bus.DataIn <= data_sh;
            end
            if (state_nxt == RD_SET) begin
                bus.Addr <= addr_sh[REG_ADDR_W-1:0];
            end
            if (state == RD_CAP && state_nxt == RD_OUT) begin
                bus.RbData <= bus.DataOut;
                bus.RbAddr <= addr_sr;
            end
        end
    end
endmodule

// File: tb/tb_cnfg_reg_access.sv
// Randomised bench for cnfg_reg_access with a register-file model
// and a word-level reference of register contents.
module tb_cnfg_reg_access;
    localparam int CMD_ADDR_W = 6;
    localparam int REG_ADDR_W = 5;
    localparam int DATA_W     = 16;
    localparam int WE_CYCLES  = 1;
    localparam int NREG       = 1 << REG_ADDR_W;

    logic Clk    = 1'b0;
    logic ResetB = 1'b0;

    int n_cmp = 0;
    int n_err = 0;

    cnfg_reg_access_if #(
        .CMD_ADDR_W(CMD_ADDR_W),
        .REG_ADDR_W(REG_ADDR_W),
        .DATA_W    (DATA_W)
    ) bus ();

    cnfg_reg_access #(
        .CMD_ADDR_W(CMD_ADDR_W),
        .REG_ADDR_W(REG_ADDR_W),
        .DATA_W    (DATA_W),
        .WE_CYCLES (WE_CYCLES)
    ) dut (
        .Clk   (Clk),
        .ResetB(ResetB),
        .bus   (bus)
    );

    always #5 Clk = ~Clk;

    // register file environment
    logic [DATA_W-1:0] rf [NREG] = '{default: '0};
    always @(posedge Clk) if (bus.WE) rf[bus.Addr] <= bus.DataIn;
    assign bus.DataOut = rf[bus.Addr];

    // reference contents
    logic [DATA_W-1:0]     ref_mem   [NREG] = '{default: '0};
    bit                    ref_known [NREG] = '{default: 1'b1};
    logic [REG_ADDR_W-1:0] last_wa = '0;
    logic [DATA_W-1:0]     last_wd = '0;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // output monitor
    bit                    mon_quiet = 0;
    logic                  mon_we_q  = 0;
    logic                  rbv_q     = 0;
    logic [REG_ADDR_W-1:0] mon_addr_q = '0;
    logic [DATA_W-1:0]     mon_data_q = '0;
    logic [REG_ADDR_W-1:0] we_addr = '0;
    logic [DATA_W-1:0]     we_data = '0;
    int we_width = 0;
    int we_cnt   = 0;
    int aerr_cnt = 0;
    int rbv_cnt  = 0;

    always @(negedge Clk) begin
        if (!mon_quiet) begin
            if (bus.WE && !mon_we_q) begin
                we_cnt++;
                we_width = 1;
                we_addr  = bus.Addr;
                we_data  = bus.DataIn;
                chk("we_setup_addr", bus.Addr, mon_addr_q);
                chk("we_setup_data", bus.DataIn, mon_data_q);
            end else if (bus.WE) begin
                we_width++;
            end else if (mon_we_q) begin
                chk("we_width", we_width, WE_CYCLES);
                chk("we_hold_addr", bus.Addr, we_addr);
                chk("we_hold_data", bus.DataIn, we_data);
            end
            if (bus.AddrErr) aerr_cnt++;
            if (bus.RbValid && !rbv_q) rbv_cnt++;
        end
        mon_we_q   = bus.WE;
        rbv_q      = bus.RbValid;
        mon_addr_q = bus.Addr;
        mon_data_q = bus.DataIn;
    end

    task automatic send_bit(input logic b, input int gap);
        if (gap < 0) begin
            bus.SerValid = 1'b0;
            bus.SerIn    = 1'($urandom);
            @(negedge Clk);
        end else begin
            while ($urandom_range(99) < gap) begin
                bus.SerValid = 1'b0;
                bus.SerIn    = 1'($urandom);
                @(negedge Clk);
            end
        end
        bus.SerValid = 1'b1;
        bus.SerIn    = b;
        @(negedge Clk);
        bus.SerValid = 1'b0;
    endtask

    task automatic send_cmd(input bit rd, input logic [CMD_ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int gap);
        @(negedge Clk);
        bus.Start  = 1'b1;
        bus.OpRead = rd;
        @(negedge Clk);
        bus.Start  = 1'b0;
        bus.OpRead = 1'b0;
        chk("busy_rise", bus.Busy, 1);
        for (int i = CMD_ADDR_W - 1; i >= 0; i--) send_bit(a[i], gap);
        if (!rd) for (int i = DATA_W - 1; i >= 0; i--) send_bit(d[i], gap);
    endtask

    task automatic wait_idle(output int lat);
        lat = 0;
        while (bus.Busy && lat < 100) begin
            @(negedge Clk);
            lat++;
        end
        if (lat >= 100) chk("idle_timeout", bus.Busy, 0);
    endtask

    task automatic do_write(input logic [CMD_ADDR_W-1:0] a,
                            input logic [DATA_W-1:0] d, input int gap);
        int we0 = we_cnt;
        int ae0 = aerr_cnt;
        int lat;
        bit bad = (a >> REG_ADDR_W) != 0;
        send_cmd(1'b0, a, d, gap);
        wait_idle(lat);
        if (bad) begin
            chk("wr_err_nowe", we_cnt - we0, 0);
            chk("wr_err_pulse", aerr_cnt - ae0, 1);
        end else begin
            chk("wr_lat", lat, 2 + WE_CYCLES);
            chk("wr_we_cnt", we_cnt - we0, 1);
            chk("wr_we_addr", we_addr, a[REG_ADDR_W-1:0]);
            chk("wr_we_data", we_data, d);
            ref_mem[a[REG_ADDR_W-1:0]]   = d;
            ref_known[a[REG_ADDR_W-1:0]] = 1'b1;
            last_wa = a[REG_ADDR_W-1:0];
            last_wd = d;
        end
    endtask

    task automatic do_read(input logic [CMD_ADDR_W-1:0] a, input int gap,
                           input int bp_pct, input int hold);
        int we0 = we_cnt;
        int ae0 = aerr_cnt;
        int rb0 = rbv_cnt;
        int cyc;
        int held = 0;
        bit done = 0;
        bit seen = 0;
        bit bad  = (a >> REG_ADDR_W) != 0;
        send_cmd(1'b1, a, '0, gap);
        if (bad) begin
            wait_idle(cyc);
            chk("rd_err_pulse", aerr_cnt - ae0, 1);
            repeat (2) @(negedge Clk);
            chk("rd_err_novalid", rbv_cnt - rb0, 0);
            return;
        end
        cyc = 1;
        while (!done && cyc < 200) begin
            bus.Start = 1'b0;
            if (bus.RbValid) begin
                if (!seen) begin
                    seen = 1;
                    chk("rd_lat", cyc, 3);
                end
                chk("rb_addr", bus.RbAddr, a);
                if (ref_known[a[REG_ADDR_W-1:0]])
                    chk("rb_data", bus.RbData, ref_mem[a[REG_ADDR_W-1:0]]);
                if (held < hold) begin
                    bus.RbReady = 1'b0;
                    held++;
                    if (held == hold / 2) bus.Start = 1'b1;
                end else if ($urandom_range(99) >= bp_pct) begin
                    bus.RbReady = 1'b1;
                    done = 1;
                end else begin
                    bus.RbReady = 1'b0;
                end
            end
            @(negedge Clk);
            cyc++;
        end
        bus.RbReady = 1'b0;
        bus.Start   = 1'b0;
        chk("rd_done", done, 1);
        chk("rd_release", {bus.Busy, bus.RbValid}, 0);
        chk("rd_no_we", we_cnt - we0, 0);
        last_wa = a[REG_ADDR_W-1:0];
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int we0;
        int lat;
        logic [CMD_ADDR_W-1:0] ra;
        logic [DATA_W-1:0]     rd;

        bus.Start    = 1'b0;
        bus.OpRead   = 1'b0;
        bus.SerIn    = 1'b0;
        bus.SerValid = 1'b0;
        bus.Abort    = 1'b0;
        bus.RbReady  = 1'b0;

        repeat (3) @(negedge Clk);
        chk("rst_ctrl", {bus.Busy, bus.WE, bus.RbValid, bus.AddrErr}, 0);
        chk("rst_addr", {bus.Addr, bus.RbAddr}, 0);
        chk("rst_data", {bus.DataIn, bus.RbData}, 0);
        ResetB = 1'b1;
        repeat (4) @(negedge Clk);

        do_write(6'h05, 16'hA5C3, 0);
        chk("wr_hold_after", {bus.Addr, bus.DataIn}, {5'd5, 16'hA5C3});
        do_write(6'h1F, 16'h1234, 0);
        do_read(6'h1F, 0, 0, 0);

        do_write(6'h28, 16'hFFFF, 0);
        do_read(6'h3F, 0, 0, 0);

        do_read(6'h05, -1, 0, 10);
        repeat (2) @(negedge Clk);
        chk("start_busy_ignored", bus.Busy, 0);

        // abort in S_DATA after 8 data bits
        we0 = we_cnt;
        @(negedge Clk);
        bus.Start = 1'b1;
        @(negedge Clk);
        bus.Start = 1'b0;
        for (int i = CMD_ADDR_W - 1; i >= 0; i--) send_bit(1'(6'h0A >> i), 0);
        for (int i = 0; i < 8; i++) send_bit(1'($urandom), 0);
        bus.Abort = 1'b1;
        @(negedge Clk);
        bus.Abort = 1'b0;
        chk("abort_data_busy", bus.Busy, 0);
        for (int i = 0; i < 4; i++) send_bit(1'($urandom), 0);
        chk("abort_data_nowe", we_cnt - we0, 0);
        chk("abort_keep_addr", bus.Addr, last_wa);
        chk("abort_keep_data", bus.DataIn, last_wd);
        do_write(6'h0A, 16'h5A5A, 0);

        // abort in RD_OUT with RbReady high
        send_cmd(1'b1, 6'h1F, '0, 0);
        lat = 0;
        while (!bus.RbValid && lat < 20) begin
            @(negedge Clk);
            lat++;
        end
        chk("abort_rd_valid", bus.RbValid, 1);
        bus.Abort   = 1'b1;
        bus.RbReady = 1'b1;
        @(negedge Clk);
        bus.Abort   = 1'b0;
        bus.RbReady = 1'b0;
        chk("abort_rd_drop", {bus.Busy, bus.RbValid}, 0);
        do_read(6'h1F, 0, 0, 0);

        // asynchronous reset during the write pulse
        send_cmd(1'b0, 6'h07, 16'hBEEF, 0);
        @(negedge Clk);
        chk("rst_we_pre", bus.WE, 1);
        mon_quiet = 1;
        #1 ResetB = 1'b0;
        #1;
        chk("rst_async_we", bus.WE, 0);
        chk("rst_async_ctrl", {bus.Busy, bus.RbValid, bus.AddrErr}, 0);
        chk("rst_async_addr", {bus.Addr, bus.RbAddr}, 0);
        chk("rst_async_data", {bus.DataIn, bus.RbData}, 0);
        ref_known[7] = 1'b0;
        last_wa = '0;
        last_wd = '0;
        @(negedge Clk);
        ResetB = 1'b1;
        repeat (4) @(negedge Clk);
        mon_quiet = 0;
        @(negedge Clk);

        for (int n = 0; n < 40; n++) begin
            ra = ($urandom_range(99) < 80) ? 6'($urandom_range(31))
                                           : 6'($urandom_range(63));
            rd = 16'($urandom);
            if ($urandom_range(1) == 1)
                do_read(ra, $urandom_range(40), $urandom_range(60), 0);
            else
                do_write(ra, rd, $urandom_range(40));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
